can_bit_timing: RTL and testbench

CAN_BIT_TIMING -- requirements
Module: can_bit_timing

---
 rtl/can_bit_timing_if.sv | 25 ++
 rtl/can_bit_timing.sv | 186 ++++++++++++++++++
 tb/tb_can_bit_timing.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/can_bit_timing_if.sv
// Signal bundle for the CAN bit timing block: bus level and sync control in,
// sample / transmit timing pulses out. master = protocol controller side.
interface can_bit_timing_if;
   logic rx;
   logic hard_sync_en;
   logic sample;
   logic rx_bit;
   logic tx_point;

   modport master (
      output rx,
      output hard_sync_en,
      input  sample,
      input  rx_bit,
      input  tx_point
   );

   modport slave (
      input  rx,
      input  hard_sync_en,
      output sample,
      output rx_bit,
      output tx_point
   );
endinterface

// File: rtl/can_bit_timing.sv
// CAN bit timing: tq prescaler, SYNC/TSEG1/TSEG2 sequencing, hard sync and resync.
// Optional macro CAN_TRIPLE_SAMPLE_EN selects majority-of-three sampling at the end of TSEG1.
module can_bit_timing #(
   parameter int FREQ_I     = 50_000_000,
   parameter int FREQ_O     = 50_000,
   parameter int PROP_SEG   = 3,
   parameter int PHASE_SEG1 = 3,
   parameter int PHASE_SEG2 = 3,
   parameter int SJW        = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rx_i,
   input  logic hard_sync_en_i,
   output logic sample_o,
   output logic rx_bit_o,
   output logic tx_point_o
);

   localparam int NTQ = 1 + PROP_SEG + PHASE_SEG1 + PHASE_SEG2;
   localparam int BRP = FREQ_I / (FREQ_O * NTQ);
   localparam int TQW = 8;

   localparam logic [15:0]    BRP_LAST  = 16'(BRP - 1);
   localparam logic [TQW-1:0] TSEG1_NOM = TQW'(PROP_SEG + PHASE_SEG1);
   localparam logic [TQW-1:0] TSEG2_NOM = TQW'(PHASE_SEG2);
   localparam logic [TQW-1:0] SJW_TQ    = TQW'(SJW);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TSEG1 = 2'd1,
      ST_TSEG2 = 2'd2
   } state_t;

   logic [1:0]     sync_q;
   logic           prev_q;
   logic [15:0]    presc_q, presc_d;
   state_t         state_q, state_d;
   logic [TQW-1:0] tq_q, tq_d;
   logic [TQW-1:0] len1_q, len1_d;
   logic [TQW-1:0] len2_q, len2_d;
   logic           done_q, done_d;
   logic           sample_q, sample_d;
   logic           tx_q, tx_d;
   logic           rx_bit_q, rx_bit_d;

   logic           synced, fall_edge, hard_sync, resync_ok;
   logic           pos_resync, neg_resync, restart, sync_evt, tick, sampled_bit;
   logic [TQW-1:0] remain, jump;
   state_t         st_eff;
   logic [TQW-1:0] tq_eff, len1_eff, len2_eff;
   logic [15:0]    presc_eff;

   assign synced     = sync_q[1];
   assign fall_edge  = prev_q & ~synced;
   assign hard_sync  = fall_edge & hard_sync_en_i & ~done_q;
   assign resync_ok  = fall_edge & ~hard_sync_en_i & ~done_q;
   assign remain     = len2_q - tq_q;
   assign jump       = ((tq_q + TQW'(1)) < SJW_TQ) ? (tq_q + TQW'(1)) : SJW_TQ;
   assign pos_resync = resync_ok & (state_q == ST_TSEG1);
   assign neg_resync = resync_ok & (state_q == ST_TSEG2) & (remain > SJW_TQ);
   assign restart    = hard_sync | (resync_ok & (state_q == ST_TSEG2) & (remain <= SJW_TQ));
   assign sync_evt   = restart | pos_resync | neg_resync;

`ifdef CAN_TRIPLE_SAMPLE_EN
   logic [1:0] hist_q, hist_d;

   assign sampled_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & synced) | (hist_q[0] & synced);

   always_comb begin
      hist_d = hist_q;
      if (tick && (st_eff == ST_TSEG1)) begin
         hist_d = {hist_q[0], synced};
      end
   end
`else
   assign sampled_bit = synced;
`endif

   // A restart makes the detecting cycle the first prescaler count of TSEG1 tq 0.
   always_comb begin
      st_eff    = state_q;
      tq_eff    = tq_q;
      presc_eff = presc_q;
      len1_eff  = len1_q;
      len2_eff  = len2_q;
      if (restart) begin
         st_eff    = ST_TSEG1;
         tq_eff    = '0;
         presc_eff = '0;
         len1_eff  = TSEG1_NOM;
         len2_eff  = TSEG2_NOM;
      end else if (pos_resync) begin
         len1_eff = len1_q + jump;
      end else if (neg_resync) begin
         len2_eff = len2_q - SJW_TQ;
      end
   end

   assign tick = (presc_eff == BRP_LAST);

   always_comb begin
      presc_d  = tick ? 16'd0 : presc_eff + 16'd1;
      state_d  = st_eff;
      tq_d     = tq_eff;
      len1_d   = len1_eff;
      len2_d   = len2_eff;
      sample_d = 1'b0;
      tx_d     = restart;
      rx_bit_d = rx_bit_q;
      done_d   = done_q | sync_evt;
      if (tick) begin
         case (st_eff)
            ST_SYNC: begin
               state_d = ST_TSEG1;
               tq_d    = '0;
            end
            ST_TSEG1: begin
               if (tq_eff == len1_eff - TQW'(1)) begin
                  state_d  = ST_TSEG2;
                  tq_d     = '0;
                  sample_d = 1'b1;
                  rx_bit_d = sampled_bit;
                  done_d   = sync_evt;
               end else begin
                  tq_d = tq_eff + TQW'(1);
               end
            end
            ST_TSEG2: begin
               if (tq_eff == len2_eff - TQW'(1)) begin
                  state_d = ST_SYNC;
                  tq_d    = '0;
                  tx_d    = 1'b1;
                  len1_d  = TSEG1_NOM;
                  len2_d  = TSEG2_NOM;
               end else begin
                  tq_d = tq_eff + TQW'(1);
               end
            end
            default: begin
               state_d = ST_SYNC;
               tq_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q   <= 2'b11;
         prev_q   <= 1'b1;
         presc_q  <= '0;
         state_q  <= ST_SYNC;
         tq_q     <= '0;
         len1_q   <= TSEG1_NOM;
         len2_q   <= TSEG2_NOM;
         done_q   <= 1'b0;
         sample_q <= 1'b0;
         tx_q     <= 1'b0;
         rx_bit_q <= 1'b1;
`ifdef CAN_TRIPLE_SAMPLE_EN
         hist_q   <= 2'b11;
`endif
      end else begin
         sync_q   <= {sync_q[0], rx_i};
         prev_q   <= sync_q[1];
         presc_q  <= presc_d;
         state_q  <= state_d;
         tq_q     <= tq_d;
         len1_q   <= len1_d;
         len2_q   <= len2_d;
         done_q   <= done_d;
         sample_q <= sample_d;
         tx_q     <= tx_d;
         rx_bit_q <= rx_bit_d;
`ifdef CAN_TRIPLE_SAMPLE_EN
         hist_q   <= hist_d;
`endif
      end
   end

   assign sample_o   = sample_q;
   assign tx_point_o = tx_q;
   assign rx_bit_o   = rx_bit_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: scenario table, reset corner cases, and a randomized
// run against a position-in-bit reference model.
module tb_can_bit_timing;

   localparam int BRP  = 50_000_000 / (50_000 * 10);
   localparam int NOM1 = 6;
   localparam int NOM2 = 3;
   localparam int SJWV = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   can_bit_timing_if bus();

   can_bit_timing #(
      .FREQ_I(50_000_000),
      .FREQ_O(50_000),
      .PROP_SEG(3),
      .PHASE_SEG1(3),
      .PHASE_SEG2(3),
      .SJW(1)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .rx_i(bus.rx),
      .hard_sync_en_i(bus.hard_sync_en),
      .sample_o(bus.sample),
      .rx_bit_o(bus.rx_bit),
      .tx_point_o(bus.tx_point)
   );

   always #5 clk = ~clk;

   typedef struct {
      int fall1;
      int rise1;
      int fall2;
      int rise2;
      bit hse;
      int tx1;
      int smp1;
      int smp2;
      int bit1;
   } vec_t;

   vec_t vecs[8];
   int n_cmp = 0;
   int n_err = 0;

   // reference model state: position in the current bit, in clk cycles
   int  m_pos, m_len1, m_len2;
   bit  m_done, m_d1, m_d2, m_d3;
   bit  m_s, m_t, m_bit;
   bit  m_hist[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit level(input vec_t v, input int c);
      bit l;
      l = 1'b1;
      if (v.fall1 >= 0 && c >= v.fall1) l = 1'b0;
      if (v.rise1 >= 0 && c >= v.rise1) l = 1'b1;
      if (v.fall2 >= 0 && c >= v.fall2) l = 1'b0;
      if (v.rise2 >= 0 && c >= v.rise2) l = 1'b1;
      return l;
   endfunction

   // Leaves the bench at the falling edge of cycle 0 after release.
   task automatic do_reset();
      rst = 1'b1;
      bus.rx = 1'b1;
      bus.hard_sync_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_row(input int i);
      int tx1, s1, s2, b1;
      tx1 = -1; s1 = -1; s2 = -1; b1 = -1;
      do_reset();
      bus.hard_sync_en = vecs[i].hse;
      for (int c = 0; c < 2000; c++) begin
         if (bus.tx_point === 1'b1 && tx1 < 0) tx1 = c;
         if (bus.sample === 1'b1) begin
            if (s1 < 0) begin
               s1 = c;
               b1 = (bus.rx_bit === 1'b1) ? 1 : 0;
            end else if (s2 < 0) begin
               s2 = c;
            end
         end
         bus.rx = level(vecs[i], c);
         @(negedge clk);
      end
      check($sformatf("row%0d_tx1", i), tx1, vecs[i].tx1);
      check($sformatf("row%0d_smp1", i), s1, vecs[i].smp1);
      check($sformatf("row%0d_smp2", i), s2, vecs[i].smp2);
      check($sformatf("row%0d_bit1", i), b1, vecs[i].bit1);
      $display("row %0d: tx1=%0d smp1=%0d smp2=%0d bit1=%0d", i, tx1, s1, s2, b1);
   endtask

   task automatic mid_reset(input int at);
      int got;
      got = -1;
      do_reset();
      repeat (at) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check($sformatf("rst%0d_outs", at),
            int'({bus.sample, bus.tx_point, bus.rx_bit}), 1);
      rst = 1'b0;
      for (int c = 0; c < 1100; c++) begin
         if (bus.sample === 1'b1) begin
            got = c;
            break;
         end
         @(negedge clk);
      end
      check($sformatf("rst%0d_first_smp", at), got, 700);
      $display("reset at %0d: first sample after release at %0d", at, got);
   endtask

   task automatic model_reset();
      m_pos = 0; m_len1 = NOM1; m_len2 = NOM2;
      m_done = 1'b0;
      m_d1 = 1'b1; m_d2 = 1'b1; m_d3 = 1'b1;
      m_s = 1'b0; m_t = 1'b0; m_bit = 1'b1;
      m_hist = '{1'b1, 1'b1, 1'b1};
   endtask

   task automatic model_step(input bit rx_now, input bit hse_now);
      bit synced, edge_seen, ev, nx_s, nx_t;
      int end1, endb, e, r, n;
      synced = m_d2;
      edge_seen = m_d3 && !m_d2;
      ev = 1'b0; nx_s = 1'b0; nx_t = 1'b0;
      end1 = BRP * (1 + m_len1);
      if (edge_seen && !m_done) begin
         if (hse_now) begin
            m_pos = BRP; m_len1 = NOM1; m_len2 = NOM2; nx_t = 1'b1; ev = 1'b1;
         end else if (m_pos >= BRP && m_pos < end1) begin
            e = (m_pos - BRP) / BRP;
            m_len1 += (e + 1 < SJWV) ? e + 1 : SJWV;
            ev = 1'b1;
         end else if (m_pos >= end1) begin
            r = m_len2 - (m_pos - end1) / BRP;
            if (r <= SJWV) begin
               m_pos = BRP; m_len1 = NOM1; m_len2 = NOM2; nx_t = 1'b1;
            end else begin
               m_len2 -= SJWV;
            end
            ev = 1'b1;
         end
      end
      end1 = BRP * (1 + m_len1);
      endb = end1 + BRP * m_len2;
      if (m_pos >= BRP && m_pos < end1 && (m_pos % BRP) == BRP - 1) begin
         m_hist.push_back(synced);
         if (m_hist.size() > 3) void'(m_hist.pop_front());
      end
      if (m_pos == end1 - 1) begin
         nx_s = 1'b1;
`ifdef CAN_TRIPLE_SAMPLE_EN
         n = int'(m_hist[0]) + int'(m_hist[1]) + int'(m_hist[2]);
         m_bit = (n >= 2);
`else
         n = 0;
         m_bit = synced;
`endif
         m_done = 1'b0;
      end
      if (ev) m_done = 1'b1;
      if (m_pos == endb - 1) begin
         m_pos = 0; m_len1 = NOM1; m_len2 = NOM2; nx_t = 1'b1;
      end else begin
         m_pos++;
      end
      m_d3 = m_d2; m_d2 = m_d1; m_d1 = rx_now;
      m_s = nx_s; m_t = nx_t;
   endtask

   task automatic run_random(input int ncyc);
      bit rxv, hsev;
      int nsmp;
      rxv = 1'b1; hsev = 1'b0; nsmp = 0;
      do_reset();
      model_reset();
      for (int c = 0; c < ncyc; c++) begin
         if (bus.sample === 1'b1 || bus.tx_point === 1'b1 || m_s || m_t) begin
            check($sformatf("rand_c%0d", c),
                  int'({bus.sample, bus.tx_point, bus.rx_bit}), int'({m_s, m_t, m_bit}));
            if (m_s) begin
               nsmp++;
               $display("random: sample %0d at cycle %0d, bit=%0d", nsmp, c, m_bit);
            end
         end
         if ($urandom_range(0, 149) == 0) rxv = ~rxv;
         if ($urandom_range(0, 499) == 0) hsev = ~hsev;
         bus.rx = rxv;
         bus.hard_sync_en = hsev;
         model_step(rxv, hsev);
         @(negedge clk);
      end
   endtask

   initial begin
      //          fall1 rise1 fall2 rise2 hse  tx1  smp1 smp2 bit1
      vecs[0] = '{-1,   -1,   -1,   -1,   0,  1000, 700, 1700, 1};
      vecs[1] = '{250,  -1,   -1,   -1,   1,   253, 852, 1852, 0};
      vecs[2] = '{300,  350,  450,  -1,   0,  1100, 800, 1800, 0};
      vecs[3] = '{948,  -1,   -1,   -1,   0,   951, 700, 1550, 1};
      vecs[4] = '{718,  -1,   -1,   -1,   0,   900, 700, 1600, 1};
`ifdef CAN_TRIPLE_SAMPLE_EN
      vecs[5] = '{98,   200,  750,  850,  0,  1100, 800, 1800, 1};
`else
      vecs[5] = '{98,   200,  750,  850,  0,  1100, 800, 1800, 0};
`endif
      vecs[6] = '{48,   -1,   -1,   -1,   0,  1000, 700, 1700, 0};
      vecs[7] = '{48,   -1,   -1,   -1,   1,    51, 650, 1650, 0};

      rst = 1'b1;
      bus.rx = 1'b1;
      bus.hard_sync_en = 1'b0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("reset_outs%0d", k),
               int'({bus.sample, bus.tx_point, bus.rx_bit}), 1);
         bus.rx = k[0];
      end
      $display("reset hold: outputs checked over 4 cycles");

      for (int i = 0; i < 8; i++) run_row(i);

      mid_reset(650);
      mid_reset(699);

      run_random(12000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
